// File: rtl/ddr4_pkg.sv
// ddr4_pkg: shared state, command encodings and address split for the DDR4 scheduler
package ddr4_pkg;
   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_ACT, S_RCD_WAIT, S_RW, S_CAS_WAIT, S_PRE, S_RP_WAIT, S_REF, S_RFC_WAIT
   } state_t;
   typedef logic [3:0] cmd_t;
   localparam cmd_t CMD_DES = 4'b1111;
   localparam cmd_t CMD_NOP = 4'b0111;
   localparam cmd_t CMD_ACT = 4'b0011;
   localparam cmd_t CMD_RD  = 4'b0101;
   localparam cmd_t CMD_WR  = 4'b0100;
   localparam cmd_t CMD_PRE = 4'b0010;
   localparam cmd_t CMD_REF = 4'b0001;
   localparam int COL_BITS = 10;
   function automatic logic [31:0] row_addr(input logic [31:0] a);
      return {{COL_BITS{1'b0}}, a[31:COL_BITS]};
   endfunction
   function automatic logic [31:0] col_addr(input logic [31:0] a);
      return {{(32 - COL_BITS){1'b0}}, a[COL_BITS-1:0]};
   endfunction
endpackage

// File: rtl/ddr4_rr_arbiter.sv
// ddr4_rr_arbiter: 2-way round-robin, the requester not granted last wins a tie
module ddr4_rr_arbiter (
   input  logic [1:0] req,
   input  logic       enable,
   input  logic       last_grant,
   output logic [1:0] grant
);
   assign grant = !enable ? 2'b00 : (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/ddr4_cmd_scheduler.sv
// ddr4_cmd_scheduler: closed-page ACT/RW/PRE sequencer for two requesters with
// power-up CKE sequencing and periodic auto-refresh on a shared DFI command path
module ddr4_cmd_scheduler
   import ddr4_pkg::*;
#(
   parameter int T_INIT = 8,
   parameter int T_RCD  = 4,
   parameter int T_CAS  = 6,
   parameter int T_RP   = 4,
   parameter int T_RFC  = 16,
   parameter int T_REFI = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_we,
   input  logic [31:0] req_addr0,
   input  logic [31:0] req_addr1,
   input  logic [15:0] req_wdata0,
   input  logic [15:0] req_wdata1,
   output logic [1:0]  req_ready,
   output logic [1:0]  req_done,
   output logic        init_done,
   output logic        cs_n,
   output logic        ras_n,
   output logic        cas_n,
   output logic        we_n,
   output logic        cke,
   output logic [31:0] addr,
   output logic [15:0] data_out,
   output logic        wrdata_mask
);
   state_t      state;
   cmd_t        cmd;
   logic [15:0] cnt;
   logic [15:0] refi_cnt;
   logic        ref_pending;
   logic        last_grant;
   logic        we_q;
   logic [31:0] addr_q;
   logic [15:0] wdata_q;
   logic [1:0]  grant;

   ddr4_rr_arbiter u_arb (
      .req        (req_valid),
      .enable     (state == S_IDLE && !ref_pending),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign req_ready = grant;
   assign {cs_n, ras_n, cas_n, we_n} = cmd;

   // Outputs are loaded on entry to each state, so the registered pins show the
   // command of the state being occupied; waits hold cnt = remaining cycles - 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_INIT;
         cmd         <= CMD_DES;
         cnt         <= '0;
         refi_cnt    <= '0;
         ref_pending <= 1'b0;
         last_grant  <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cke         <= 1'b0;
         init_done   <= 1'b0;
         addr        <= '0;
         data_out    <= '0;
         wrdata_mask <= 1'b1;
         req_done    <= 2'b00;
      end else begin
         req_done <= 2'b00;
         case (state)
            S_INIT: begin
               if (cnt == 16'(T_INIT - 1)) begin
                  state     <= S_IDLE;
                  cmd       <= CMD_NOP;
                  cke       <= 1'b1;
                  init_done <= 1'b1;
                  refi_cnt  <= 16'(T_REFI - 1);
               end else cnt <= cnt + 16'd1;
            end
            S_IDLE: begin
               if (ref_pending) begin
                  state       <= S_REF;
                  cmd         <= CMD_REF;
                  ref_pending <= 1'b0;
               end else if (|grant) begin
                  state      <= S_ACT;
                  cmd        <= CMD_ACT;
                  last_grant <= grant[1];
                  we_q       <= req_we[grant[1]];
                  addr_q     <= grant[1] ? req_addr1 : req_addr0;
                  wdata_q    <= grant[1] ? req_wdata1 : req_wdata0;
                  addr       <= row_addr(grant[1] ? req_addr1 : req_addr0);
               end
            end
            S_ACT: begin
               state <= S_RCD_WAIT;
               cmd   <= CMD_NOP;
               addr  <= '0;
               cnt   <= 16'(T_RCD - 2);
            end
            S_RCD_WAIT: begin
               if (cnt == '0) begin
                  state       <= S_RW;
                  cmd         <= we_q ? CMD_WR : CMD_RD;
                  addr        <= col_addr(addr_q);
                  data_out    <= we_q ? wdata_q : '0;
                  wrdata_mask <= !we_q;
               end else cnt <= cnt - 16'd1;
            end
            S_RW: begin
               state <= S_CAS_WAIT;
               cmd   <= CMD_NOP;
               addr  <= '0;
               cnt   <= 16'(T_CAS - 2);
            end
            S_CAS_WAIT: begin
               if (cnt == '0) begin
                  state       <= S_PRE;
                  cmd         <= CMD_PRE;
                  data_out    <= '0;
                  wrdata_mask <= 1'b1;
                  req_done    <= last_grant ? 2'b10 : 2'b01;
               end else cnt <= cnt - 16'd1;
            end
            S_PRE: begin
               state <= S_RP_WAIT;
               cmd   <= CMD_NOP;
               cnt   <= 16'(T_RP - 2);
            end
            S_RP_WAIT: begin
               if (cnt == '0) state <= S_IDLE;
               else cnt <= cnt - 16'd1;
            end
            S_REF: begin
               state <= S_RFC_WAIT;
               cmd   <= CMD_NOP;
               cnt   <= 16'(T_RFC - 2);
            end
            S_RFC_WAIT: begin
               if (cnt == '0) state <= S_IDLE;
               else cnt <= cnt - 16'd1;
            end
            default: state <= S_INIT;
         endcase
         // A new expiry wins over the clear, so one landing on the REF edge stays pending.
         if (state != S_INIT) begin
            if (refi_cnt == '0) begin
               refi_cnt    <= 16'(T_REFI - 1);
               ref_pending <= 1'b1;
            end else refi_cnt <= refi_cnt - 16'd1;
         end
      end
   end
endmodule
